shifter_8bit: RTL and testbench
===============================

// Module: shifter_8bit
// PURPOSE
//  8-bit registered shifter. Holds one byte and, each clock, either keeps it,
//  loads a new byte, or shifts it by 0..3 bits (logical left/right, arithmetic right).
//  Standalone datapath leaf: the controller drives op/shamt; d_out is the register.
// PARAMETERS
//  none (width fixed at 8, shift amount fixed at 2 bits)
// PORTS
//  clk      in   1  rising-edge clock, the only clock
//  reset_n  in   1  asynchronous, active-low reset
//  op       in   3  operation code, sampled at each rising edge
//  shamt    in   2  shift amount 0..3, used only by the shift ops
//  d_in     in   8  load data, used only by LOAD
//  d_out    out  8  current register contents (registered output)
// BEHAVIOUR
//  - reset_n=0: d_out clears to 8'h00 at once, without waiting for clk; held while low.
//  - Single 8-bit register; next value is computed combinationally from op, shamt,
//    d_in and d_out, and is captured on each rising clk edge. Latency 1 cycle.
//  - op decode (next d_out):
//      000 NOP  : d_out (hold)
//      001 LOAD : d_in
//      010 LSL  : d_out << shamt, zero fill from the right
//      011 LSR  : d_out >> shamt, zero fill from the left
//      100 ASR  : d_out >>> shamt, fill with d_out[7]
//      101..111 : hold (unless SHIFTER8_ROTATE_EN, see CONFIGURATION)
//  - shamt=0 on any shift op: hold. Bits shifted out are discarded; no carry output.
//  - Shifts repeat every cycle while op stays a shift op (the shift accumulates).
//  - Changes on op/shamt/d_in between edges have no effect until the next edge.
//  - Reset asserted mid-operation overrides everything. The first edge after
//    reset_n rises applies op normally.
//  - No X propagation from unused inputs: d_in is ignored except for LOAD, and
//    shamt is ignored for NOP and LOAD.
// CONFIGURATION
//  - SHIFTER8_ROTATE_EN defined:
//      op 101 is ROL: d_out rotated left by shamt.
//      op 110 is ROR: d_out rotated right by shamt.
//      op 111 holds.
//  - Not defined: ops 101..111 all hold. Port list is identical in both builds.
// TESTING
//  - Reset: reset_n=0 at t=0 with clk running -> d_out=00. Assert reset_n mid-cycle
//    with d_out=5A -> d_out=00 before the next edge.
//  - Load/hold: LOAD d_in=77 -> d_out=77 after 1 edge. Then op=000 -> stays 77.
//  - LSL: from 77, op=010 shamt=0 -> 77. Then shamt=1 over two edges -> EE, then DC.
//  - LSR then ASR: from DC, op=011 shamt=1 -> 6E, 37. Then op=100 shamt=1 -> 1B, 0D, 06.
//  - ASR sign fill: LOAD 80, op=100 shamt=3 -> F0, then FE. Same start with
//    op=011 shamt=3 -> 10, then 02.
//  - Reserved/rotate: LOAD 81, op=101 shamt=1. With SHIFTER8_ROTATE_EN -> 03.
//    Without it -> 81. op=110 shamt=2 on 81 with the macro -> 60.

Source files
------------

// File: rtl/shifter_8bit.sv
// ---------------------------------------------------------------------------
// shifter_8bit
//   8-bit registered shifter. Each rising clock edge the held byte is kept,
//   replaced with d_in, or shifted by 0..3 bits. The shift ops are logical
//   left, logical right and arithmetic right. Shifting accumulates while a
//   shift op is held. Bits shifted out are discarded.
//
//   Build option: SHIFTER8_ROTATE_EN
//     defined   : op 101 = rotate left, op 110 = rotate right, op 111 = hold
//     undefined : ops 101..111 hold
//   The port list is the same in both builds.
//
// Ports
//   clk      in   1  rising-edge clock
//   reset_n  in   1  asynchronous active-low reset, clears d_out to 8'h00
//   op       in   3  operation code, sampled at each rising edge
//   shamt    in   2  shift amount 0..3, used by shift/rotate ops only
//   d_in     in   8  load data, used by LOAD only
//   d_out    out  8  register contents
// ---------------------------------------------------------------------------
module shifter_8bit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] op,
    input  logic [1:0] shamt,
    input  logic [7:0] d_in,
    output logic [7:0] d_out
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_LSL  = 3'b010,
        OP_LSR  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSV  = 3'b111
    } op_e;

    logic [7:0] r_data;
    logic [7:0] w_next;
    op_e        w_op;

    assign w_op = op_e'(op);

    always_comb begin
        w_next = r_data;
        case (w_op)
            OP_LOAD: w_next = d_in;
            OP_LSL:  w_next = r_data << shamt;
            OP_LSR:  w_next = r_data >> shamt;
            OP_ASR:  w_next = $unsigned($signed(r_data) >>> shamt);
`ifdef SHIFTER8_ROTATE_EN
            OP_ROL: begin
                case (shamt)
                    2'd1:    w_next = {r_data[6:0], r_data[7]};
                    2'd2:    w_next = {r_data[5:0], r_data[7:6]};
                    2'd3:    w_next = {r_data[4:0], r_data[7:5]};
                    default: w_next = r_data;
                endcase
            end
            OP_ROR: begin
                case (shamt)
                    2'd1:    w_next = {r_data[0],   r_data[7:1]};
                    2'd2:    w_next = {r_data[1:0], r_data[7:2]};
                    2'd3:    w_next = {r_data[2:0], r_data[7:3]};
                    default: w_next = r_data;
                endcase
            end
`endif
            default: w_next = r_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_next;
        end
    end

    assign d_out = r_data;

endmodule

// File: tb/tb_shifter_8bit.sv
module tb_shifter_8bit;

    logic       clk;
    logic       reset_n;
    logic [2:0] op;
    logic [1:0] shamt;
    logic [7:0] d_in;
    logic [7:0] d_out;

    int n_checks = 0;
    int n_errors = 0;

    shifter_8bit u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (op),
        .shamt   (shamt),
        .d_in    (d_in),
        .d_out   (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [1:0] sh;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [2:0] o, input logic [1:0] s,
                           input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.op = o; v.sh = s; v.din = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        op = o; shamt = s; d_in = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: arithmetic on integer byte values, not bit slicing.
    function automatic int ref_next(int v, int o, int s, int d);
        int r;
        int p;
        p = 2 ** s;
        case (o)
            0: r = v;
            1: r = d;
            2: r = (v * p) % 256;
            3: r = v / p;
            4: begin
                r = v;
                for (int i = 0; i < s; i++) r = (r / 2) + ((r >= 128) ? 128 : 0);
            end
`ifdef SHIFTER8_ROTATE_EN
            5: r = ((v * p) % 256) + v / (2 ** (8 - s));
            6: r = (v / p) + ((v * (2 ** (8 - s))) % 256);
`endif
            default: r = v;
        endcase
        return r;
    endfunction

    localparam logic [7:0] EXP_ROL = `ifdef SHIFTER8_ROTATE_EN 8'h03 `else 8'h81 `endif ;
    localparam logic [7:0] EXP_ROR = `ifdef SHIFTER8_ROTATE_EN 8'h60 `else 8'h81 `endif ;

    initial begin
        int model;
        reset_n = 1'b0;
        op = 3'b000; shamt = 2'd0; d_in = 8'h00;

        // Reset held low with clock running.
        #3;
        check("reset_t0", d_out, 8'h00);
        @(posedge clk); #1;
        check("reset_held", d_out, 8'h00);

        // First edge after release applies op.
        @(negedge clk);
        reset_n = 1'b1; op = 3'b001; d_in = 8'h5A;
        @(posedge clk); #1;
        check("first_edge_load", d_out, 8'h5A);

        // Async reset mid-cycle with d_out = 5A.
        @(negedge clk);
        op = 3'b000;
        reset_n = 1'b0;
        #1;
        check("async_reset", d_out, 8'h00);
        @(posedge clk); #1;
        check("reset_over_op", d_out, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table, applied in order from a cleared register.
        add_vec(3'b001, 2'd3, 8'h77, 8'h77);
        add_vec(3'b000, 2'd2, 8'hFF, 8'h77);
        add_vec(3'b010, 2'd0, 8'h00, 8'h77);
        add_vec(3'b010, 2'd1, 8'h00, 8'hEE);
        add_vec(3'b010, 2'd1, 8'h00, 8'hDC);
        add_vec(3'b011, 2'd1, 8'h00, 8'h6E);
        add_vec(3'b011, 2'd1, 8'h00, 8'h37);
        add_vec(3'b100, 2'd1, 8'h00, 8'h1B);
        add_vec(3'b100, 2'd1, 8'h00, 8'h0D);
        add_vec(3'b100, 2'd1, 8'h00, 8'h06);
        add_vec(3'b001, 2'd0, 8'h80, 8'h80);
        add_vec(3'b100, 2'd3, 8'h00, 8'hF0);
        add_vec(3'b100, 2'd3, 8'h00, 8'hFE);
        add_vec(3'b001, 2'd0, 8'h80, 8'h80);
        add_vec(3'b011, 2'd3, 8'h00, 8'h10);
        add_vec(3'b011, 2'd3, 8'h00, 8'h02);
        add_vec(3'b100, 2'd0, 8'h00, 8'h02);
        add_vec(3'b001, 2'd0, 8'h81, 8'h81);
        add_vec(3'b101, 2'd1, 8'h00, EXP_ROL);
        add_vec(3'b001, 2'd0, 8'h81, 8'h81);
        add_vec(3'b110, 2'd2, 8'h00, EXP_ROR);
        add_vec(3'b001, 2'd0, 8'hC3, 8'hC3);
        add_vec(3'b111, 2'd1, 8'h00, 8'hC3);

        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].sh, vecs[i].din);
            check($sformatf("vec%0d", i), d_out, vecs[i].exp);
        end

        // Input changes between edges have no effect until the next edge.
        @(negedge clk);
        op = 3'b001; d_in = 8'h3C;
        #2;
        check("no_comb_path", d_out, 8'hC3);
        op = 3'b000;
        @(posedge clk); #1;
        check("late_change_nop", d_out, 8'hC3);

        // Randomized run against the reference model, with occasional resets.
        model = 32'(d_out);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                reset_n = 1'b0;
                #1;
                model = 0;
                check("rand_async_reset", d_out, 8'(model));
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                logic [2:0] o;
                logic [1:0] s;
                logic [7:0] d;
                o = 3'($urandom_range(0, 7));
                s = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                step(o, s, d);
                model = ref_next(model, int'(o), int'(s), int'(d));
                check($sformatf("rand%0d_op%0d_sh%0d", n, o, s), d_out, 8'(model));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
